// File: rtl/mult_div_unit_pkg.sv
// Shared funct codes and bus types for the multiply/divide unit.
package mult_div_unit_pkg;

    localparam int FUNCT_W = 6;
    localparam int DATA_BUS_W = 32;

    typedef logic [FUNCT_W-1:0]    funct_bus_t;
    typedef logic [DATA_BUS_W-1:0] data_bus_t;

    localparam funct_bus_t FUNCT_MFHI  = 6'h10;
    localparam funct_bus_t FUNCT_MTHI  = 6'h11;
    localparam funct_bus_t FUNCT_MFLO  = 6'h12;
    localparam funct_bus_t FUNCT_MTLO  = 6'h13;
    localparam funct_bus_t FUNCT_MULT  = 6'h18;
    localparam funct_bus_t FUNCT_MULTU = 6'h19;
    localparam funct_bus_t FUNCT_DIV   = 6'h1A;
    localparam funct_bus_t FUNCT_DIVU  = 6'h1B;

    function automatic logic is_muldiv(funct_bus_t f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_mul(funct_bus_t f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
    endfunction

    function automatic logic is_signed_op(funct_bus_t f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Pipeline-side bundle for the multiply/divide unit: request, stall/done and HI/LO.
interface mult_div_unit_if #(parameter int DATA_W = 32);

    logic                            flush;
    logic                            start;
    mult_div_unit_pkg::funct_bus_t   funct;
    logic [DATA_W-1:0]               operand_a;
    logic [DATA_W-1:0]               operand_b;
    logic                            stall_req;
    logic                            done;
    logic [DATA_W-1:0]               hi;
    logic [DATA_W-1:0]               lo;

    modport master (
        output flush, start, funct, operand_a, operand_b,
        input  stall_req, done, hi, lo
    );

    modport slave (
        input  flush, start, funct, operand_a, operand_b,
        output stall_req, done, hi, lo
    );

endinterface

// File: rtl/mult_div_unit_div_core.sv
// Restoring divider: one quotient bit per cycle, plus the iteration counter shared with the multiplier.
module mult_div_unit_div_core #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic              count_en,
    input  logic              step_en,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              last,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dvsr;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;

    // Bit DATA_W of diff is the borrow: set means the trial subtraction must be restored.
    assign shifted = {remainder, quotient[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvsr};
    assign last    = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dvsr      <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (load) begin
            cnt       <= '0;
            dvsr      <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else begin
            if (count_en)
                cnt <= cnt + 1'b1;
            if (step_en) begin
                if (!diff[DATA_W]) begin
                    remainder <= diff[DATA_W-1:0];
                    quotient  <= {quotient[DATA_W-2:0], 1'b1};
                end else begin
                    remainder <= shifted[DATA_W-1:0];
                    quotient  <= {quotient[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; MTHI/MTLO writes, stall and done handshake.
// Define MULTDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle product.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIXUP} state_t;

    state_t              state, state_nxt;
    logic                is_md, accept, signed_op, a_neg, b_neg, last;
    logic [DATA_W-1:0]   abs_a, abs_b, quo, rem, quo_fix, rem_fix;
    logic                op_mul, neg_res, neg_rem, div_zero;
    logic [2*DATA_W-1:0] prod, prod_fix;
`ifndef MULTDIV_FAST_MUL_EN
    logic [DATA_W-1:0]   mcand;
    logic [DATA_W:0]     mul_sum;
`endif

    function automatic logic [DATA_W-1:0] negate_w(logic [DATA_W-1:0] v, logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] negate_2w(logic [2*DATA_W-1:0] v, logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign is_md     = is_muldiv(bus.funct);
    assign signed_op = is_signed_op(bus.funct);
    assign a_neg     = signed_op & bus.operand_a[DATA_W-1];
    assign b_neg     = signed_op & bus.operand_b[DATA_W-1];
    assign abs_a     = negate_w(bus.operand_a, a_neg);
    assign abs_b     = negate_w(bus.operand_b, b_neg);
    assign accept    = bus.start & ~bus.done & ~bus.flush & is_md & (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.stall_req = (state != ST_IDLE) |
                        (bus.start & ~bus.done & is_md & (state == ST_IDLE));
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef MULTDIV_FAST_MUL_EN
                    state_nxt = is_mul(bus.funct) ? ST_FIXUP : ST_DIV;
`else
                    state_nxt = is_mul(bus.funct) ? ST_MUL : ST_DIV;
`endif
                end
            end
            ST_MUL:   if (last) state_nxt = ST_FIXUP;
            ST_DIV:   if (last) state_nxt = ST_FIXUP;
            ST_FIXUP: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (bus.flush)
            state_nxt = ST_IDLE;
    end

    mult_div_unit_div_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .load      (accept),
        .count_en  ((state == ST_MUL) || (state == ST_DIV)),
        .step_en   (state == ST_DIV),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .last      (last),
        .quotient  (quo),
        .remainder (rem)
    );

`ifndef MULTDIV_FAST_MUL_EN
    // Low half of prod holds the unconsumed multiplier bits; the high half accumulates.
    assign mul_sum = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
`endif

    assign prod_fix = negate_2w(prod, neg_res);
    assign quo_fix  = div_zero ? '1 : negate_w(quo, neg_res);
    assign rem_fix  = negate_w(rem, neg_rem);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_mul   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            prod     <= '0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
`ifndef MULTDIV_FAST_MUL_EN
            mcand    <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            if (!bus.flush) begin
                if (accept) begin
                    op_mul   <= is_mul(bus.funct);
                    neg_res  <= a_neg ^ b_neg;
                    neg_rem  <= a_neg;
                    div_zero <= ~is_mul(bus.funct) & (bus.operand_b == '0);
`ifdef MULTDIV_FAST_MUL_EN
                    prod     <= {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
`else
                    prod     <= {{DATA_W{1'b0}}, abs_b};
                    mcand    <= abs_a;
`endif
                end
`ifndef MULTDIV_FAST_MUL_EN
                if (state == ST_MUL)
                    prod <= {mul_sum, prod[DATA_W-1:1]};
`endif
                if (state == ST_FIXUP) begin
                    bus.done <= 1'b1;
                    if (op_mul) begin
                        bus.hi <= prod_fix[2*DATA_W-1:DATA_W];
                        bus.lo <= prod_fix[DATA_W-1:0];
                    end else begin
                        bus.hi <= rem_fix;
                        bus.lo <= quo_fix;
                    end
                end
                if ((state == ST_IDLE) && bus.start) begin
                    if (bus.funct == FUNCT_MTHI) bus.hi <= bus.operand_a;
                    if (bus.funct == FUNCT_MTLO) bus.lo <= bus.operand_a;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed MULT/DIV vectors, MTHI/MTLO, flush and reset.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

`ifdef MULTDIV_FAST_MUL_EN
    localparam int MUL_STALL = 2;
`else
    localparam int MUL_STALL = 34;
`endif
    localparam int DIV_STALL = 34;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_div_unit_if #(.DATA_W(32)) bus();

    mult_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_hi"}, {32'd0, bus.hi}, {32'd0, mon_e.hi});
                check({mon_e.name, "_lo"}, {32'd0, bus.lo}, {32'd0, mon_e.lo});
            end
        end
    end

    task automatic do_op(input string name, input funct_bus_t f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi_e, input logic [31:0] lo_e,
                         input int stall_e);
        exp_t e;
        int   n;
        bit   ok;
        n  = 0;
        ok = 0;
        @(posedge clk); #1;
        e.name = name;
        e.hi   = hi_e;
        e.lo   = lo_e;
        sb.push_back(e);
        bus.start     = 1'b1;
        bus.funct     = f;
        bus.operand_a = a;
        bus.operand_b = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.stall_req) begin
                ok = 1;
                break;
            end
            n++;
            @(posedge clk); #1;
        end
        if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
        check({name, "_stall_cycles"}, 64'(n), 64'(stall_e));
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check({name, "_done_single"}, {63'd0, bus.done}, 64'd0);
    endtask

    task automatic move_to(input string name, input funct_bus_t f, input logic [31:0] v);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.funct     = f;
        bus.operand_a = v;
        @(negedge clk);
        check({name, "_no_stall"}, {63'd0, bus.stall_req}, 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.start     = 1'b0;
        bus.funct     = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        #1;
        check("reset_hi", {32'd0, bus.hi}, 64'd0);
        check("reset_lo", {32'd0, bus.lo}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        check("reset_stall", {63'd0, bus.stall_req}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op("mult_neg2x3",   FUNCT_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MUL_STALL);
        do_op("multu_max",     FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_STALL);
        do_op("div_neg7_2",    FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_STALL);
        do_op("divu_by_zero",  FUNCT_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, DIV_STALL);
        do_op("div_overflow",  FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_STALL);
        do_op("div_neg_by_0",  FUNCT_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, DIV_STALL);
        do_op("multu_carry",   FUNCT_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MUL_STALL);
        do_op("mult_6x7",      FUNCT_MULT,  32'd6,        32'd7,        32'd0,        32'd42,       MUL_STALL);
        do_op("div_neg_divsr", FUNCT_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, DIV_STALL);

        move_to("mthi", FUNCT_MTHI, 32'h0000ABCD);
        move_to("mtlo", FUNCT_MTLO, 32'h00001234);
        @(negedge clk);
        check("mthi_value", {32'd0, bus.hi}, 64'h0000ABCD);
        check("mtlo_value", {32'd0, bus.lo}, 64'h00001234);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.funct = FUNCT_MFLO;
        @(negedge clk);
        check("mflo_no_stall", {63'd0, bus.stall_req}, 64'd0);
        check("mflo_value", {32'd0, bus.lo}, 64'h00001234);
        @(posedge clk); #1;
        bus.start = 1'b0;

        // Flush ten iterations into a divide: back to idle, HI/LO untouched, no done.
        bus.start     = 1'b1;
        bus.funct     = FUNCT_DIVU;
        bus.operand_a = 32'd1000;
        bus.operand_b = 32'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_idle", {63'd0, bus.stall_req}, 64'd0);
        check("flush_hi_kept", {32'd0, bus.hi}, 64'h0000ABCD);
        check("flush_lo_kept", {32'd0, bus.lo}, 64'h00001234);
        repeat (40) @(negedge clk);
        check("flush_still_idle", {63'd0, bus.stall_req}, 64'd0);

        // Asynchronous reset in the middle of a divide.
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.funct     = FUNCT_DIV;
        bus.operand_a = 32'd77;
        bus.operand_b = 32'd5;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", {63'd0, bus.stall_req}, 64'd1);
        rst_n     = 1'b0;
        bus.start = 1'b0;
        #1;
        check("midop_reset_hi", {32'd0, bus.hi}, 64'd0);
        check("midop_reset_lo", {32'd0, bus.lo}, 64'd0);
        check("midop_reset_done", {63'd0, bus.done}, 64'd0);
        check("midop_reset_stall", {63'd0, bus.stall_req}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op("divu_after_rst", FUNCT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_STALL);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
